// File: rtl/shift_loader_pkg.sv
// Shared types and constants for the serial-to-parallel loader.
// Holds the FSM state type, the default word width and the delivered-word counter width.
// No logic lives here; the block imports it.
package shift_loader_pkg;

  // Collecting bits, or holding a complete word in the shift register.
  typedef enum logic [0:0] {
    COLLECT = 1'b0,
    FULL    = 1'b1
  } state_t;

  localparam int DEF_WIDTH = 4;
  localparam int WCNT_W    = 8;

endpackage

// File: rtl/shift_loader.sv
// Assembles serial bits into a WIDTH-bit word and presents it, registered, on A.
// Latency: one edge from acceptance of the last bit to a_valid when the output slot is free.
// Backpressure: a completed word waits in sh while A is occupied; ser_ready drops until it moves.
module shift_loader
  import shift_loader_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int MSB_FIRST = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ser_in,
  input  logic              ser_valid,
  output logic              ser_ready,
  output logic [WIDTH-1:0]  A,
  output logic              a_valid,
  input  logic              out_ready,
  output logic [WCNT_W-1:0] word_cnt
);

  // cnt has to hold WIDTH itself while a full word is parked.
  localparam int CNT_W = $clog2(WIDTH + 1);

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   sh;
  logic [WIDTH-1:0]   sh_shifted;
  logic               accept;
  logic               last_bit;
  logic               slot_free;
  logic               load_a;
  logic               take;

  // Ready depends only on the state, so no combinational path from ser_valid.
  assign ser_ready = (state == COLLECT);
  assign accept    = ser_valid && ser_ready;
  assign last_bit  = accept && (cnt == CNT_W'(WIDTH - 1));
  assign slot_free = !a_valid || out_ready;
  assign take      = a_valid && out_ready;
  // A is loaded either straight from the completing shift or from the parked word.
  assign load_a    = slot_free && (last_bit || (state == FULL));

  // Shift register contents after accepting ser_in in the configured direction.
  always_comb begin
    sh_shifted = sh;
    if (MSB_FIRST != 0) begin
      sh_shifted = {sh[WIDTH-2:0], ser_in};
    end else begin
      sh_shifted = {ser_in, sh[WIDTH-1:1]};
    end
  end

  // Bit collection: shift register, bit counter and COLLECT/FULL state.
  always_ff @(posedge clk) begin
    if (rst) begin
      sh    <= '0;
      cnt   <= '0;
      state <= COLLECT;
    end else begin
      if (accept) begin
        sh <= sh_shifted;
      end
      case (state)
        COLLECT: begin
          if (last_bit) begin
            if (slot_free) begin
              cnt <= '0;
            end else begin
              cnt   <= CNT_W'(WIDTH);
              state <= FULL;
            end
          end else if (accept) begin
            cnt <= cnt + 1'b1;
          end
        end
        FULL: begin
          if (slot_free) begin
            cnt   <= '0;
            state <= COLLECT;
          end
        end
        default: begin
          cnt   <= '0;
          state <= COLLECT;
        end
      endcase
    end
  end

  // Output slot: a load wins over a simultaneous take, so a_valid stays set.
  always_ff @(posedge clk) begin
    if (rst) begin
      A       <= '0;
      a_valid <= 1'b0;
    end else if (load_a) begin
      A       <= (state == FULL) ? sh : sh_shifted;
      a_valid <= 1'b1;
    end else if (take) begin
      a_valid <= 1'b0;
    end
  end

  // Count words handed downstream, wrapping naturally at 2**WCNT_W.
  always_ff @(posedge clk) begin
    if (rst) begin
      word_cnt <= '0;
    end else if (take) begin
      word_cnt <= word_cnt + 1'b1;
    end
  end

endmodule

// File: doc/shift_loader.md
SHIFT_LOADER -- requirements
Module: shift_loader

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the parallel word width fed to the downstream 4-bit register.
REQ-002 The block SHALL have parameter MSB_FIRST, default 1, where 1 means the first serial bit lands in A[WIDTH-1] and 0 means it lands in A[0].
REQ-003 Port clk SHALL be an input, 1 bit wide, serving as the single rising-edge clock.
REQ-004 Port rst SHALL be an input, 1 bit wide, serving as a synchronous, active-high reset.
REQ-005 Port ser_in SHALL be an input, 1 bit wide, carrying serial data.
REQ-006 Port ser_valid SHALL be an input, 1 bit wide, qualifying ser_in.
REQ-007 Port ser_ready SHALL be an output, 1 bit wide, meaning the block accepts a bit this cycle.
REQ-008 Port A SHALL be an output, WIDTH bits wide, carrying the assembled word to the downstream register's A input.
REQ-009 Port a_valid SHALL be an output, 1 bit wide, meaning A holds an undelivered word.
REQ-010 Port out_ready SHALL be an input, 1 bit wide, meaning the downstream consumer takes A this cycle.
REQ-011 Port word_cnt SHALL be an output, 8 bits wide, counting delivered words modulo 256.

Function
REQ-012 The block SHALL accept a bit on any rising clk edge where ser_valid=1 and ser_ready=1.
- Bits offered while ser_ready=0 are ignored.
REQ-013 Shift direction on each accepted bit SHALL be:
- MSB_FIRST=1: sh <= {sh[WIDTH-2:0], ser_in}.
- MSB_FIRST=0: sh <= {ser_in, sh[WIDTH-1:1]}.
REQ-014 The FSM SHALL have two states, COLLECT and FULL:
- COLLECT: bit counter cnt runs 0..WIDTH-1; ser_ready=1.
- FULL: cnt=WIDTH; ser_ready=0.
REQ-015 The output slot SHALL be "free" in a cycle when a_valid=0 or out_ready=1.
REQ-016 On the edge accepting the WIDTH-th bit with the slot free, the block SHALL:
- load A with the completed word;
- set a_valid=1;
- clear cnt to 0 and stay in COLLECT.
- There is no bubble: the next bit is accepted on the following cycle.
REQ-017 On the edge accepting the WIDTH-th bit with the slot not free, the block SHALL:
- hold the word in sh;
- set cnt=WIDTH and enter FULL.
REQ-018 In FULL, on the first edge where the slot is free, the block SHALL:
- transfer sh to A and set a_valid=1;
- clear cnt to 0 and return to COLLECT;
- assert ser_ready again from the next cycle.
REQ-019 Latency from WIDTH-th bit acceptance to a_valid=1 SHALL be one edge, given a free slot.
REQ-020 a_valid SHALL clear on an edge with a_valid=1, out_ready=1, and no transfer into A.
REQ-021 When a transfer and a downstream take occur on the same edge, a_valid SHALL stay 1 and A SHALL carry the new word.
REQ-022 A SHALL remain stable while a_valid=1 and out_ready=0.
REQ-023 word_cnt SHALL increment by 1 on every edge with a_valid=1 and out_ready=1, wrapping 255 -> 0.
REQ-024 Outputs SHALL be registered; no combinational path SHALL run from ser_in to A.
- ser_ready is a function of state only.

Reset
REQ-025 With rst=1 at a rising edge, the block SHALL set:
- sh=0, cnt=0, state=COLLECT;
- A=0, a_valid=0, word_cnt=0.
REQ-026 Reset SHALL override all simultaneous handshakes, and partial words collected before reset SHALL be discarded.
REQ-027 ser_ready SHALL read 1 in the first cycle after reset deasserts.

Structure
REQ-028 Package shift_loader_pkg SHALL hold:
- the state enum (COLLECT, FULL);
- default WIDTH=4;
- the word_cnt width constant 8.
REQ-029 The block SHALL be a single module with no sub-module; the counter, shift register and output slot are simple enough to remain inline.

Verification
REQ-030 The bench SHALL cover the following directed scenarios:
- Scenario 1: MSB_FIRST=1, out_ready=1, bits 1,0,1,0 on consecutive cycles -> A=4'b1010, a_valid=1 one edge after the 4th bit, word_cnt=1.
- Scenario 2: MSB_FIRST=0, bits 0,0,1,1 -> A=4'b1100.
- Scenario 3: out_ready=0, words 1010 then 1100 streamed.
  - First word: A=1010 is held.
  - Second word: after its 4th bit, ser_ready=0 (FULL).
  - Raise out_ready for one cycle -> A=1100 on the next edge, a_valid stays 1, ser_ready returns to 1.
- Scenario 4: continuous stream 0011,1010 with out_ready=1 -> back-to-back words with no idle cycle; ser_ready constantly 1.
- Scenario 5: rst=1 after 2 of 4 bits -> cnt=0, A=0, a_valid=0; a fresh word 0011 then assembles correctly.
- Scenario 6: deliver 256 words -> word_cnt wraps from 255 to 0.
